// File: rtl/divisor_secuencial.sv
// divisor_secuencial: sequential signed divider, restoring radix-2 on magnitudes.
// Takes a 2N-bit signed dividend and an N-bit signed divisor and produces an
// N-bit signed quotient (truncated toward zero, saturated on overflow) and an
// N-bit signed remainder carrying the dividend's sign. One quotient bit per clock.
// All values are two's complement carried in plain logic vectors.
module divisor_secuencial #(
   parameter int N = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [2*N-1:0] dividend,
   input  logic [N-1:0]   divisor,
   output logic [N-1:0]   quotient,
   output logic [N-1:0]   remainder,
   output logic           busy,
   output logic           done,
   output logic           div_by_zero,
   output logic           overflow
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      ZERO = 2'd3
   } state_t;

   localparam int CW = $clog2(2*N+1);
   localparam logic [CW-1:0]  ITER    = CW'(2*N);
   localparam logic [CW-1:0]  CNT_ONE = CW'(1);
   // 2^(N-1) as a 2N-bit magnitude: the boundary of the representable quotient range
   localparam logic [2*N-1:0] HALF    = {{N{1'b0}}, 1'b1, {(N-1){1'b0}}};
   localparam logic [N-1:0]   QMAX    = {1'b0, {(N-1){1'b1}}};
   localparam logic [N-1:0]   QMIN    = {1'b1, {(N-1){1'b0}}};

   state_t         state_q,     state_d;
   logic [CW-1:0]  count_q,     count_d;
   logic [N-1:0]   acc_q,       acc_d;
   logic [2*N-1:0] shf_q,       shf_d;
   logic [N-1:0]   dvs_q,       dvs_d;
   logic           dvd_neg_q,   dvd_neg_d;
   logic           dvs_neg_q,   dvs_neg_d;
   logic [N-1:0]   quotient_q,  quotient_d;
   logic [N-1:0]   remainder_q, remainder_d;
   logic           busy_q,      busy_d;
   logic           done_q,      done_d;
   logic           dbz_q,       dbz_d;
   logic           ovf_q,       ovf_d;

   logic [2*N-1:0] dvd_mag;
   logic [N-1:0]   dvs_mag;
   logic [N:0]     rem_shift;
   logic           fits;
   logic [N-1:0]   trial;
   logic           q_neg;
   logic           q_ovf;
   logic [N-1:0]   q_signed;
   logic [N-1:0]   q_sat;
   logic [N-1:0]   r_signed;

   // Datapath helpers: operand magnitudes, one restoring step, and sign fix-up values
   always_comb begin
      dvd_mag   = dividend[2*N-1] ? -dividend : dividend;
      dvs_mag   = divisor[N-1] ? -divisor : divisor;
      rem_shift = {acc_q, shf_q[2*N-1]};
      fits      = (rem_shift >= {1'b0, dvs_q});
      trial     = rem_shift[N-1:0] - dvs_q;
      q_neg     = dvd_neg_q ^ dvs_neg_q;
      q_ovf     = q_neg ? (shf_q > HALF) : (shf_q >= HALF);
      q_signed  = q_neg ? -shf_q[N-1:0] : shf_q[N-1:0];
      q_sat     = q_neg ? QMIN : QMAX;
      r_signed  = dvd_neg_q ? -acc_q : acc_q;
   end

   // Next-state and next-output logic for the IDLE/CALC/FIX/ZERO sequence
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      acc_d       = acc_q;
      shf_d       = shf_q;
      dvs_d       = dvs_q;
      dvd_neg_d   = dvd_neg_q;
      dvs_neg_d   = dvs_neg_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      dbz_d       = dbz_q;
      ovf_d       = ovf_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               dvd_neg_d = dividend[2*N-1];
               dvs_neg_d = divisor[N-1];
               shf_d     = dvd_mag;
               dvs_d     = dvs_mag;
               acc_d     = '0;
               count_d   = ITER;
               busy_d    = 1'b1;
               state_d   = (divisor == '0) ? ZERO : CALC;
            end
         end
         CALC: begin
            acc_d   = fits ? trial : rem_shift[N-1:0];
            shf_d   = {shf_q[2*N-2:0], fits};
            count_d = count_q - CNT_ONE;
            if (count_q == CNT_ONE) begin
               state_d = FIX;
            end
         end
         FIX: begin
            quotient_d  = q_ovf ? q_sat : q_signed;
            remainder_d = r_signed;
            ovf_d       = q_ovf;
            dbz_d       = 1'b0;
            done_d      = 1'b1;
            busy_d      = 1'b0;
            state_d     = IDLE;
         end
         ZERO: begin
            quotient_d  = '0;
            remainder_d = '0;
            ovf_d       = 1'b0;
            dbz_d       = 1'b1;
            done_d      = 1'b1;
            busy_d      = 1'b0;
            state_d     = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, datapath and registered outputs; reset aborts any division in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         count_q     <= '0;
         acc_q       <= '0;
         shf_q       <= '0;
         dvs_q       <= '0;
         dvd_neg_q   <= 1'b0;
         dvs_neg_q   <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         dbz_q       <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         acc_q       <= acc_d;
         shf_q       <= shf_d;
         dvs_q       <= dvs_d;
         dvd_neg_q   <= dvd_neg_d;
         dvs_neg_q   <= dvs_neg_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         dbz_q       <= dbz_d;
         ovf_q       <= ovf_d;
      end
   end

   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign div_by_zero = dbz_q;
   assign overflow    = ovf_q;

endmodule

// File: tb/tb_divisor_secuencial.sv
// tb_divisor_secuencial: self-checking bench for divisor_secuencial.
// Expected results come from plain signed longint / and % with saturation.
module tb_divisor_secuencial;

   localparam int     N    = 16;
   localparam int     LAT  = 2*N + 1;
   localparam longint QMAX = (longint'(1) <<< (N-1)) - 1;
   localparam longint QMIN = -(longint'(1) <<< (N-1));

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           start = 1'b0;
   logic [2*N-1:0] dividend = '0;
   logic [N-1:0]   divisor = '0;
   logic [N-1:0]   quotient;
   logic [N-1:0]   remainder;
   logic           busy;
   logic           done;
   logic           div_by_zero;
   logic           overflow;

   int checks = 0;
   int passes = 0;

   divisor_secuencial #(.N(N)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .quotient    (quotient),
      .remainder   (remainder),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .overflow    (overflow)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   // Hard time limit so the bench can never hang
   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: time limit reached, got running, expected finished");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input longint observed, input longint expected);
      checks++;
      if (observed == expected) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Present operands with start high and return just after the accepting edge
   task automatic applyStimulus(input longint a, input longint b);
      dividend = a[2*N-1:0];
      divisor  = b[N-1:0];
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Wait (bounded) for done and compare everything against the arithmetic model
   task automatic awaitResult(input string tag, input longint a, input longint b, input int elapsed);
      longint eq, er;
      longint eovf, edbz;
      int     elat, lat;
      longint busy_held;
      if (b == 0) begin
         eq = 0; er = 0; eovf = 0; edbz = 1; elat = 1;
      end else begin
         eq   = a / b;
         er   = a % b;
         edbz = 0;
         eovf = ((eq > QMAX) || (eq < QMIN)) ? 1 : 0;
         if (eq > QMAX) eq = QMAX;
         else if (eq < QMIN) eq = QMIN;
         elat = LAT;
      end
      lat = elapsed;
      busy_held = 1;
      while (done !== 1'b1 && lat < 200) begin
         if (busy !== 1'b1) busy_held = 0;
         @(posedge clk);
         #1;
         lat++;
      end
      checkOutput({tag, " latency"}, longint'(lat), longint'(elat));
      checkOutput({tag, " busy held"}, busy_held, 1);
      checkOutput({tag, " busy at done"}, longint'(busy), 0);
      checkOutput({tag, " quotient"}, longint'($signed(quotient)), eq);
      checkOutput({tag, " remainder"}, longint'($signed(remainder)), er);
      checkOutput({tag, " overflow"}, longint'(overflow), eovf);
      checkOutput({tag, " div_by_zero"}, longint'(div_by_zero), edbz);
   endtask

   longint ta [7];
   longint tbv [7];
   longint saw_done;
   longint ra, rb;
   logic [31:0] r32;
   logic [15:0] r16a, r16b;
   int mode;

   initial begin
      ta[0] = -100;  tbv[0] = 7;
      ta[1] = 100;   tbv[1] = -7;
      ta[2] = -100;  tbv[2] = -7;
      ta[3] = 65536; tbv[3] = 1;
      ta[4] = -(longint'(1) <<< 31); tbv[4] = -1;
      ta[5] = -32768; tbv[5] = 1;
      ta[6] = -65536; tbv[6] = 1;

      // Reset state
      #12;
      checkOutput("reset quotient", longint'(quotient), 0);
      checkOutput("reset remainder", longint'(remainder), 0);
      checkOutput("reset busy", longint'(busy), 0);
      checkOutput("reset done", longint'(done), 0);
      checkOutput("reset div_by_zero", longint'(div_by_zero), 0);
      checkOutput("reset overflow", longint'(overflow), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Basic division and done pulse width
      @(negedge clk);
      applyStimulus(100, 7);
      checkOutput("basic busy after start", longint'(busy), 1);
      awaitResult("basic", 100, 7, 0);
      @(posedge clk);
      #1;
      checkOutput("basic done one cycle", longint'(done), 0);

      // Sign combinations and overflow boundaries
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         applyStimulus(ta[i], tbv[i]);
         awaitResult($sformatf("table%0d", i), ta[i], tbv[i], 0);
      end

      // Divide by zero, then flag cleared by a normal result
      @(negedge clk);
      applyStimulus(1234, 0);
      awaitResult("dbz", 1234, 0, 0);
      @(negedge clk);
      applyStimulus(10, 3);
      awaitResult("after dbz", 10, 3, 0);

      // Start while busy is ignored
      @(negedge clk);
      applyStimulus(100, 7);
      repeat (9) @(posedge clk);
      #1;
      dividend = 32'd50;
      divisor  = 16'd5;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      awaitResult("ignored start", 100, 7, 10);

      // Start in the done cycle is accepted
      @(negedge clk);
      applyStimulus(20, 3);
      awaitResult("b2b first", 20, 3, 0);
      applyStimulus(9, 2);
      awaitResult("b2b second", 9, 2, 0);

      // Reset mid-operation
      @(negedge clk);
      applyStimulus(1000, 9);
      repeat (15) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("abort quotient", longint'(quotient), 0);
      checkOutput("abort remainder", longint'(remainder), 0);
      checkOutput("abort busy", longint'(busy), 0);
      #10;
      @(negedge clk);
      rst_n = 1'b1;
      saw_done = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) saw_done = 1;
      end
      checkOutput("abort no done", saw_done, 0);
      @(negedge clk);
      applyStimulus(-5000, 33);
      awaitResult("after abort", -5000, 33, 0);

      // Randomized operands
      for (int k = 0; k < 40; k++) begin
         mode = int'($urandom_range(0, 3));
         r32  = $urandom;
         r16a = 16'($urandom);
         r16b = 16'($urandom);
         case (mode)
            0: ra = longint'($signed(r32));
            1: ra = longint'($signed(r16a));
            default: ra = longint'($signed(r16a)) * longint'($signed(r16b));
         endcase
         r16b = 16'($urandom);
         rb = (mode == 3 && r16b[0]) ? 0 : longint'($signed(r16b));
         @(negedge clk);
         applyStimulus(ra, rb);
         awaitResult($sformatf("rand%0d", k), ra, rb, 0);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/divisor_secuencial.md
# divisor_secuencial

Sequential signed divider: the inverse of the project's combinational signed multiplier. It takes a 2N-bit signed dividend (the multiplier's product width) and an N-bit signed divisor. It returns an N-bit signed quotient and remainder using a radix-2 restoring algorithm on magnitudes, one quotient bit per clock. It sits beside the multiplier in the arithmetic datapath, used where a product must be scaled back down or a ratio computed, with a start/done handshake toward the controlling FSM.

## Interface
- N, default 16; word width, instantiated with the project word-width macro `N.
- clk  input  1  rising-edge clock, the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; sampled only while busy=0.
- dividend  input  2N  signed dividend; sampled on the accepting edge.
- divisor  input  N  signed divisor; sampled on the accepting edge.
- quotient  output  N  signed quotient, registered.
- remainder  output  N  signed remainder, registered.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse when results are valid.
- div_by_zero  output  1  result flag: divisor was 0.
- overflow  output  1  result flag: true quotient not representable in N bits.

## Operation
- Reset (asynchronous, rst_n=0) forces the FSM to IDLE and clears the iteration counter.
- Reset clears all outputs to 0: quotient, remainder, busy, done, div_by_zero, overflow.
- Reset mid-operation aborts the division. No done is produced.
- The FSM has four states: IDLE, CALC, FIX, ZERO.
- IDLE:
  - Transition: if start=1, capture the operands' signs and magnitudes, load the counter with 2N, and set busy=1.
  - Go to ZERO if divisor==0; otherwise go to CALC.
  - Capture: |dividend| is 2N-bit unsigned, so -2^(2N-1) is handled; |divisor| is N-bit unsigned.
- CALC:
  - Each cycle, shift the partial remainder left, bringing in the next dividend bit (MSB first).
  - Trial-subtract |divisor|. If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
  - Decrement the counter. After 2N iterations, go to FIX.
- FIX:
  - Apply signs. The quotient is negated when the operand signs differ; the remainder takes the dividend's sign. This is truncation toward zero, matching Verilog signed / and %.
  - If the signed quotient lies outside [-2^(N-1), 2^(N-1)-1], set overflow=1. Saturate the quotient to 2^(N-1)-1 if positive, or -2^(N-1) if negative.
  - The remainder is always representable and is output unsaturated.
  - Register the outputs, pulse done, clear busy, and return to IDLE.
- ZERO: register quotient=0, remainder=0, div_by_zero=1, overflow=0; pulse done, clear busy, return to IDLE.
- Result registers and flags hold their values until the next done. Flags are cleared on any done that does not set them.
- A start while busy=1 is ignored: operands are not resampled and the running division is unaffected.

## Timing
- Edge 0 samples start=1 with busy=0. busy is high after edge 0.
- Normal path: CALC iterations occur on edges 1..2N, and FIX occurs on edge 2N+1.
  - done is high for exactly one cycle, between edges 2N+1 and 2N+2 (33 edges after the start edge for N=16).
  - busy falls on the same edge that raises done.
- Zero divisor: done is high between edges 1 and 2.
- Back-to-back operation: start may be asserted in the done cycle. It is accepted, because busy=0 in that cycle, giving a throughput of one result per 2N+2 cycles.
- Outputs change only on done edges or on reset. All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Basic division (N=16):** dividend=100, divisor=7, start pulse. Required: done 33 edges later with quotient=14, remainder=2, overflow=0, div_by_zero=0; busy high for exactly 33 cycles.
- **Signs:** -100/7 gives Q=-14, R=-2. 100/-7 gives Q=-14, R=2. -100/-7 gives Q=14, R=-2.
- **Overflow:**
  - 65536/1 gives overflow=1, Q=32767, R=0.
  - -2^31/-1 gives overflow=1, Q=32767.
  - -32768/1 gives overflow=0, Q=-32768.
  - -65536/1 gives overflow=1, Q=-32768.
- **Divide by zero:** 1234/0 gives done one edge after start, Q=0, R=0, div_by_zero=1. A following 10/3 gives Q=3, R=1 with div_by_zero cleared.
- **Handshake:**
  - Start 100/7, then pulse start with 50/5 at edge 10. Required: the second start is ignored and the result is Q=14, R=2.
  - Assert start 9/2 in the done cycle. Required: accepted, giving Q=4, R=1 33 edges later.
- **Reset mid-operation:** rst_n low at edge 15 of a division. Required: outputs zero immediately (asynchronous), no done, and the next start/result is correct.
